// File: rtl/mul4_fitness_eval.sv
// Fitness evaluator: drives LFSR operand pairs to a candidate 32x32 multiplier and
// scores its 64-bit product against an internal shift-add reference.
module mul4_fitness_eval #(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [15:0]                          a1,
  output logic [15:0]                          a0,
  output logic [15:0]                          b1,
  output logic [15:0]                          b0,
  input  logic [15:0]                          y3,
  input  logic [15:0]                          y2,
  input  logic [15:0]                          y1,
  input  logic [15:0]                          y0,
  output logic [$clog2(64*NUM_VECTORS+1)-1:0]  score,
  output logic [$clog2(NUM_VECTORS+1)-1:0]     exact
);

  // state | meaning
  // IDLE  | waiting for start
  // GEN_A | latch operand A from LFSR
  // GEN_B | latch operand B, load reference multiplier
  // MUL   | 32 shift-add steps
  // CMP   | sample candidate, accumulate score
  // DONE  | one-cycle completion pulse
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GEN_A = 3'd1;
  localparam logic [2:0] GEN_B = 3'd2;
  localparam logic [2:0] MUL   = 3'd3;
  localparam logic [2:0] CMP   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam int          SW       = $clog2(64*NUM_VECTORS+1);
  localparam int          EW       = $clog2(NUM_VECTORS+1);
  localparam logic [31:0] MASK     = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [2:0]    state;
  logic [31:0]   lfsr;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [63:0]   p;
  logic [4:0]    mcnt;
  logic [EW-1:0] vcnt;

  logic [31:0]   lfsr_nxt;
  logic [32:0]   acc;
  logic [63:0]   y_cat;
  logic [6:0]    match_cnt;
  logic [EW-1:0] vcnt_inc;

  always_comb begin
    lfsr_nxt  = (lfsr >> 1) ^ (lfsr[0] ? MASK : 32'd0);
    acc       = {1'b0, p[63:32]} + {1'b0, op_a};
    y_cat     = {y3, y2, y1, y0};
    vcnt_inc  = vcnt + EW'(1);
    match_cnt = '0;
    for (int i = 0; i < 64; i++) begin
      match_cnt = match_cnt + {6'd0, ~(y_cat[i] ^ p[i])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= SEED_EFF;
      op_a  <= '0;
      op_b  <= '0;
      p     <= '0;
      mcnt  <= '0;
      vcnt  <= '0;
      score <= '0;
      exact <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= GEN_A;
            lfsr  <= SEED_EFF;
            vcnt  <= '0;
            score <= '0;
            exact <= '0;
          end
        end
        GEN_A: begin
          op_a  <= lfsr;
          lfsr  <= lfsr_nxt;
          state <= GEN_B;
        end
        GEN_B: begin
          op_b  <= lfsr;
          lfsr  <= lfsr_nxt;
          p     <= {32'd0, lfsr};
          mcnt  <= 5'd31;
          state <= MUL;
        end
        MUL: begin
          // carry out of the 32-bit add lands in P[63] after the shift
          if (p[0]) p <= {acc, p[31:1]};
          else      p <= {1'b0, p[63:1]};
          mcnt <= mcnt - 5'd1;
          if (mcnt == 5'd0) state <= CMP;
        end
        CMP: begin
          score <= score + SW'(match_cnt);
          exact <= exact + EW'(y_cat == p);
          vcnt  <= vcnt_inc;
          if (vcnt_inc < EW'(NUM_VECTORS)) state <= GEN_A;
          else                             state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == GEN_A) || (state == GEN_B) || (state == MUL) || (state == CMP);
  assign done = (state == DONE);
  assign a1   = op_a[31:16];
  assign a0   = op_a[15:0];
  assign b1   = op_b[31:16];
  assign b0   = op_b[15:0];

endmodule

// File: tb/tb_mul4_fitness_eval.sv
// Directed bench for mul4_fitness_eval: one single-vector and one 64-vector instance,
// each driven by a behavioural candidate (exact, all-zero or inverted product).
module tb_mul4_fitness_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // single-vector instance
  logic        rst1, start1, busy1, done1;
  logic [15:0] a1_1, a0_1, b1_1, b0_1, y3_1, y2_1, y1_1, y0_1;
  logic [6:0]  score1;
  logic [0:0]  exact1;
  logic [1:0]  mode1;
  logic [63:0] prod1, yv1;

  // 64-vector instance
  logic        rst64, start64, busy64, done64;
  logic [15:0] a1_64, a0_64, b1_64, b0_64, y3_64, y2_64, y1_64, y0_64;
  logic [12:0] score64;
  logic [6:0]  exact64;
  logic [1:0]  mode64;
  logic [63:0] prod64, yv64;

  mul4_fitness_eval #(.NUM_VECTORS(1), .SEED(32'h0000_0001)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
    .a1(a1_1), .a0(a0_1), .b1(b1_1), .b0(b0_1),
    .y3(y3_1), .y2(y2_1), .y1(y1_1), .y0(y0_1),
    .score(score1), .exact(exact1)
  );

  mul4_fitness_eval #(.NUM_VECTORS(64), .SEED(32'h0000_0001)) u_dut64 (
    .clk(clk), .rst(rst64), .start(start64), .busy(busy64), .done(done64),
    .a1(a1_64), .a0(a0_64), .b1(b1_64), .b0(b0_64),
    .y3(y3_64), .y2(y2_64), .y1(y1_64), .y0(y0_64),
    .score(score64), .exact(exact64)
  );

  // candidate: 0 = exact product, 1 = all zeros, 2 = inverted product
  always_comb begin
    prod1 = {32'd0, a1_1, a0_1} * {32'd0, b1_1, b0_1};
    case (mode1)
      2'd0:    yv1 = prod1;
      2'd1:    yv1 = '0;
      default: yv1 = ~prod1;
    endcase
    prod64 = {32'd0, a1_64, a0_64} * {32'd0, b1_64, b0_64};
    case (mode64)
      2'd0:    yv64 = prod64;
      2'd1:    yv64 = '0;
      default: yv64 = ~prod64;
    endcase
  end
  assign {y3_1, y2_1, y1_1, y0_1}     = yv1;
  assign {y3_64, y2_64, y1_64, y0_64} = yv64;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  function automatic logic get_done(input int which);
    return (which == 1) ? done1 : done64;
  endfunction

  function automatic logic [63:0] get_ops(input int which);
    return (which == 1) ? {a1_1, a0_1, b1_1, b0_1} : {a1_64, a0_64, b1_64, b0_64};
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 1) start1 = v;
    else            start64 = v;
  endtask

  // Launch a run, follow operands against the LFSR model, optionally poke start at
  // cycle 'poke', and return the edge index at which done is first seen (-1 on timeout).
  task automatic do_run(input int which, input int budget, input int poke, output int lat);
    logic [31:0] mdl;
    logic [31:0] ea, eb;
    mdl = 32'h0000_0001;
    lat = -1;
    @(negedge clk); set_start(which, 1'b1);
    @(posedge clk); #1 set_start(which, 1'b0);
    check_eq("busy_after_start", {63'd0, (which == 1) ? busy1 : busy64}, 64'd1);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      set_start(which, 1'b0);
      if (k % 35 == 2) begin
        ea = mdl; mdl = lfsr_step(mdl);
        eb = mdl; mdl = lfsr_step(mdl);
        check_eq("operands", get_ops(which), {ea, eb});
      end
      if (k == poke) set_start(which, 1'b1);
      if (get_done(which)) begin
        lat = k;
        break;
      end
    end
    set_start(which, 1'b0);
  endtask

  logic [12:0] exp_zero64;
  int          lat;
  logic [12:0] s_keep;

  initial begin
    logic [31:0] m, ma, mb;
    m = 32'h0000_0001;
    exp_zero64 = '0;
    for (int v = 0; v < 64; v++) begin
      ma = m; m = lfsr_step(m);
      mb = m; m = lfsr_step(m);
      exp_zero64 = exp_zero64 + 13'(64 - $countones({32'd0, ma} * {32'd0, mb}));
    end

    rst1 = 1'b1; rst64 = 1'b1; start1 = 1'b0; start64 = 1'b0;
    mode1 = 2'd0; mode64 = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy",  {62'd0, busy1, busy64}, 64'd0);
    check_eq("rst_done",  {62'd0, done1, done64}, 64'd0);
    check_eq("rst_ops1",  get_ops(1), 64'd0);
    check_eq("rst_score", {44'd0, score1, score64}, 64'd0);
    check_eq("rst_exact", {56'd0, exact1, exact64}, 64'd0);
    @(negedge clk); rst1 = 1'b0; rst64 = 1'b0;

    // single vector, exact candidate, stray start mid-run
    do_run(1, 100, 10, lat);
    check_eq("nv1_latency", 64'(lat), 64'd35);
    check_eq("nv1_ops",     get_ops(1), {32'h0000_0001, 32'h8020_0003});
    check_eq("nv1_score",   64'(score1), 64'd64);
    check_eq("nv1_exact",   64'(exact1), 64'd1);
    check_eq("nv1_busy_at_done", 64'(busy1), 64'd0);

    // start while in DONE must be ignored
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    check_eq("done_pulse_width", 64'(done1), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("start_in_done_ignored", 64'(busy1), 64'd0);
    check_eq("score_held", 64'(score1), 64'd64);

    do_run(1, 100, 0, lat);
    check_eq("rerun_latency", 64'(lat), 64'd35);
    check_eq("rerun_score",   64'(score1), 64'd64);
    check_eq("rerun_exact",   64'(exact1), 64'd1);

    @(negedge clk); mode1 = 2'd1;
    @(posedge clk); #1;
    do_run(1, 100, 0, lat);
    check_eq("zeros_latency", 64'(lat), 64'd35);
    check_eq("zeros_score",   64'(score1), 64'd60);
    check_eq("zeros_exact",   64'(exact1), 64'd0);

    @(negedge clk); mode1 = 2'd2;
    @(posedge clk); #1;
    do_run(1, 100, 0, lat);
    check_eq("inv_score", 64'(score1), 64'd0);
    check_eq("inv_exact", 64'(exact1), 64'd0);

    // 64 vectors, exact candidate
    do_run(64, 2400, 0, lat);
    check_eq("nv64_latency", 64'(lat), 64'd2240);
    check_eq("nv64_score",   64'(score64), 64'd4096);
    check_eq("nv64_exact",   64'(exact64), 64'd64);

    // 64 vectors, zero candidate: uninterrupted, then interrupted by reset and rerun
    @(negedge clk); mode64 = 2'd1;
    @(posedge clk); #1;
    do_run(64, 2400, 0, lat);
    check_eq("nv64z_latency", 64'(lat), 64'd2240);
    check_eq("nv64z_score",   64'(score64), 64'(exp_zero64));
    check_eq("nv64z_exact",   64'(exact64), 64'd0);
    s_keep = score64;

    @(negedge clk); start64 = 1'b1;
    @(posedge clk); #1 start64 = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); rst64 = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_busy",  {62'd0, busy64, done64}, 64'd0);
    check_eq("midrst_ops",   get_ops(64), 64'd0);
    check_eq("midrst_score", {44'd0, score64, exact64}, 64'd0);
    @(negedge clk); rst64 = 1'b0;

    do_run(64, 2400, 0, lat);
    check_eq("after_rst_latency", 64'(lat), 64'd2240);
    check_eq("after_rst_score",   64'(score64), 64'(s_keep));
    check_eq("after_rst_model",   64'(score64), 64'(exp_zero64));
    check_eq("after_rst_exact",   64'(exact64), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mul4_fitness_eval.md
# mul4_fitness_eval

Sequential fitness evaluator driving the operand side of a 4-word vector-multiply candidate and scoring its product side. It generates pseudo-random 32-bit operand pairs and presents them as 16-bit halves. It computes the exact 64-bit reference product with an internal shift-add multiplier and compares it bit-by-bit against the candidate's four 16-bit output words. It sits between the candidate multiplier under evaluation and the tournament/selection logic that consumes the score.

## Interface
- NUM_VECTORS, 64: operand pairs per run (≥1).
- SEED, 32'h0000_0001: LFSR reload value; 0 is replaced by 1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- busy  out  1  high from GEN_A through CMP.
- done  out  1  one-cycle pulse in DONE.
- a1, a0  out  16 each  operand A = {a1,a0} to candidate.
- b1, b0  out  16 each  operand B = {b1,b0} to candidate.
- y3, y2, y1, y0  in  16 each  candidate product words; candidate is combinational.
- score  out  $clog2(64*NUM_VECTORS+1)  total matching product bits.
- exact  out  $clog2(NUM_VECTORS+1)  vectors with all 64 bits matching.

## Operation
- States: IDLE, GEN_A, GEN_B, MUL, CMP, DONE.
- IDLE: start=1 → GEN_A. The same edge clears score, exact and the vector counter, and reloads the LFSR with SEED.
- LFSR: 32-bit Galois, right shift, mask 32'h8020_0003. Step = (s>>1) ^ (s[0] ? mask : 0).
- GEN_A: A ← lfsr, lfsr steps → GEN_B.
- GEN_B: B ← lfsr, lfsr steps; load multiplier P = {32'b0, B}, step counter 0 → MUL.
- MUL: 32 cycles of unsigned shift-add.
  - Each cycle: if P[0], add A into P[63:32] with a 33-bit carry; then shift P right by 1.
  - After 32 steps, P = A*B (64-bit, unsigned, no truncation) → CMP.
- CMP: expected words are E3=P[63:48], E2=P[47:32], E1=P[31:16], E0=P[15:0].
  - score += popcount(~({y3,y2,y1,y0} ^ P)).
  - exact += 1 iff all 64 bits match.
  - Vector counter increments; → GEN_A if counter < NUM_VECTORS, else DONE.
- DONE: done=1, → IDLE. score and exact hold until the next accepted start or rst.
- a1/a0 change only at the GEN_A edge; b1/b0 change only at the GEN_B edge. Both are stable throughout MUL and CMP.
- start is ignored in every state except IDLE, including in DONE.
- rst at any time, including mid-run, forces IDLE and clears everything below. No partial score survives.
- Reset values: busy=0, done=0, a1=a0=b1=b0=0, score=0, exact=0, LFSR=SEED (1 if SEED==0), P=0, counters=0.

## Timing
- Edge 0 samples start in IDLE.
- Per vector: 1 GEN_A + 1 GEN_B + 32 MUL + 1 CMP = 35 cycles.
- done is high in the cycle following edge 35*NUM_VECTORS. score and exact are final in that same cycle.
- busy rises in the cycle after edge 0 and falls when DONE is entered.
- The candidate is sampled only at the CMP edge. That leaves 33+ cycles after its operands settle; no combinational path from y* to any output.
- Back-to-back runs: earliest new start is accepted in the IDLE cycle after DONE, one cycle after done.

## Test plan
- NUM_VECTORS=1, SEED=1, candidate = exact multiplier. Expect A=32'h0000_0001 and B=32'h8020_0003. done arrives 35 cycles after start, with score=64 and exact=1.
- Same setup, candidate drives all zeros. Product is 64'h0000_0000_8020_0003 (4 ones), so expect score=60 and exact=0.
- Same setup, candidate drives ~(A*B). Expect score=0 and exact=0.
- NUM_VECTORS=64, SEED=1, exact multiplier. Expect done after 2240 cycles, score=4096, exact=64, and the operand sequence matching the LFSR model.
- Reset at cycle 20 of a run, then start again. Expect all outputs 0 after reset, and the second run to produce results identical to an uninterrupted run.
- start pulsed while busy and in DONE → ignored. Two consecutive runs with the same SEED give identical score and exact.
